// File: rtl/bk_port_pkg.sv
// Shared types and constants for the BK parallel-port (177714) mouse/joystick adapter.
package bk_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        CMP  = 2'd2
    } mport_state_t;

    typedef struct packed {
        logic signed [8:0] dx;
        logic signed [8:0] dy;
    } mport_pkt_t;

    localparam int DIR_YP = 0;
    localparam int DIR_XP = 1;
    localparam int DIR_YN = 2;
    localparam int DIR_XN = 3;
    localparam int BTN_L  = 5;
    localparam int BTN_R  = 6;

    localparam logic [15:0] PORT_ADDR = 16'o177714;

endpackage

// File: rtl/mport_axis.sv
// One motion axis: saturating signed accumulator, threshold compare and the +/- direction latches.
module mport_axis #(
    parameter int THR_POS = 4,
    parameter int THR_NEG = 3,
    parameter int ACC_W   = 10
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              add_stb,
    input  logic              cmp_stb,
    input  logic              clr_stb,
    input  logic signed [8:0] delta,
    output logic [1:0]        dir      // [0] = positive, [1] = negative
);

    localparam logic signed [ACC_W-1:0] TP = ACC_W'(THR_POS);
    localparam logic signed [ACC_W-1:0] TN = ACC_W'(-THR_NEG);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] acc_add;

    // One guard bit; a mismatch between the top two bits means the sum left the range.
    always_comb begin
        sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-9){delta[8]}}, delta};
        acc_add = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1])
            acc_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            dir <= '0;
        end else if (clr_stb) begin
            acc <= '0;
            dir <= '0;
        end else if (add_stb) begin
            acc <= acc_add;
        end else if (cmp_stb && dir == 2'b00) begin
            if (acc >= TP) begin
                dir[0] <= 1'b1;
                acc    <= '0;
            end else if (acc <= TN) begin
                dir[1] <= 1'b1;
                acc    <= '0;
            end
        end
    end

endmodule

// File: rtl/bk_mouse_port.sv
// BK port 177714 read word: PS/2 motion turned into latched direction bits, or the joystick state.
module bk_mouse_port
    import bk_port_pkg::*;
#(
    parameter int THR_POS = 4,
    parameter int THR_NEG = 3,
    parameter int ACC_W   = 10
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        mouse_data_ready,
    input  logic [8:0]  pointer_dx,
    input  logic [8:0]  pointer_dy,
    input  logic        left_btn,
    input  logic        right_btn,
    input  logic [7:0]  joystick,
    input  logic        port_sel,
    input  logic        port_write,
    input  logic        port_wtbt0,
    input  logic [15:0] port_din,
    output logic [15:0] port_data,
    output logic        mouse_mode,
    output logic        overrun
);

    mport_state_t state, state_nxt;
    mport_pkt_t   pkt, pend, pkt_in;
    logic         pend_vld, enable, btn_l_q, btn_r_q;
    logic         wr_lvl, wr_q, wr_hit, wr_d3, clr_stb;
    logic         pkt_ok, ld_new, ld_pend, store_pend;
    logic [1:0]   dir_x, dir_y;
    logic [3:0]   dir;
    logic         unused_din;

    assign unused_din = ^{port_din[15:4], port_din[2:0]};
    assign pkt_in     = '{dx: pointer_dx, dy: pointer_dy};
    assign pkt_ok     = mouse_data_ready & enable;
    assign wr_lvl     = port_write & port_wtbt0;
    assign clr_stb    = wr_hit & ~wr_d3;

    always_comb begin
        state_nxt = state;
        ld_new    = 1'b0;
        ld_pend   = 1'b0;
        case (state)
            IDLE: begin
                if (pend_vld) begin
                    ld_pend   = 1'b1;
                    state_nxt = ADD;
                end else if (pkt_ok) begin
                    ld_new    = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD:     state_nxt = CMP;
            CMP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Anything not captured directly goes to the one-deep slot.
        store_pend = pkt_ok & ~ld_new;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pkt        <= '0;
            pend       <= '0;
            pend_vld   <= 1'b0;
            overrun    <= 1'b0;
            mouse_mode <= 1'b0;
            enable     <= 1'b0;
            wr_q       <= 1'b0;
            wr_hit     <= 1'b0;
            wr_d3      <= 1'b0;
            btn_l_q    <= 1'b0;
            btn_r_q    <= 1'b0;
        end else begin
            btn_l_q <= left_btn;
            btn_r_q <= right_btn;

            if (ld_pend)     pkt <= pend;
            else if (ld_new) pkt <= pkt_in;

            if (store_pend) begin
                pend     <= pkt_in;
                pend_vld <= 1'b1;
                if (pend_vld && !ld_pend) overrun <= 1'b1;
            end else if (ld_pend) begin
                pend_vld <= 1'b0;
            end

            if (mouse_data_ready)   mouse_mode <= 1'b1;
            else if (joystick != 0) mouse_mode <= 1'b0;

            // Write edge is registered, then applied one cycle later.
            wr_q   <= wr_lvl;
            wr_hit <= wr_lvl & ~wr_q;
            if (wr_lvl && !wr_q) wr_d3 <= port_din[3];
            if (wr_hit) enable <= wr_d3;
        end
    end

    mport_axis #(.THR_POS(THR_POS), .THR_NEG(THR_NEG), .ACC_W(ACC_W)) u_ax_x (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .add_stb (state == ADD),
        .cmp_stb (state == CMP),
        .clr_stb (clr_stb),
        .delta   (pkt.dx),
        .dir     (dir_x)
    );

    mport_axis #(.THR_POS(THR_POS), .THR_NEG(THR_NEG), .ACC_W(ACC_W)) u_ax_y (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .add_stb (state == ADD),
        .cmp_stb (state == CMP),
        .clr_stb (clr_stb),
        .delta   (pkt.dy),
        .dir     (dir_y)
    );

    always_comb begin
        dir         = '0;
        dir[DIR_YP] = dir_y[0];
        dir[DIR_YN] = dir_y[1];
        dir[DIR_XP] = dir_x[0];
        dir[DIR_XN] = dir_x[1];

        port_data = '0;
        if (port_sel) begin
            if (mouse_mode) begin
                port_data[3:0]  = dir;
                port_data[BTN_L] = btn_l_q;
                port_data[BTN_R] = btn_r_q;
            end else begin
                port_data[7:0] = joystick;
            end
        end
    end

endmodule
